// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame constants
// and the scan-code prefixes that SOC-side decoders look for.
package ps2_keyboard_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS   = 11;
  localparam int         PS2_DATA_BITS    = 8;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO for received scan-code bytes. A pop and a push in
// the same cycle are both honoured, even when full.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: storage has no reset; rd_data is gated by empty so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the pads, decodes 11-bit
// device-to-host frames and queues good scan-code bytes for the SOC.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          kb_clk,
  input  logic                          kb_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(PS2_DATA_BITS - 1);

  logic          kb_clk_s1, kb_clk_s2, kb_data_s1, kb_data_s2;
  logic          kb_clk_f, kb_clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          fall_stb;

  ps2_state_e    state, state_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift_q, shift_n;
  logic          parity_q, parity_n;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          push;
  logic          perr_n, ferr_n;
  logic          fifo_full;

  // The pads idle high, so every stage resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kb_clk_s1  <= 1'b1;
      kb_clk_s2  <= 1'b1;
      kb_data_s1 <= 1'b1;
      kb_data_s2 <= 1'b1;
      kb_clk_f   <= 1'b1;
      kb_clk_f_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      kb_clk_s1  <= kb_clk;
      kb_clk_s2  <= kb_clk_s1;
      kb_data_s1 <= kb_data;
      kb_data_s2 <= kb_data_s1;
      kb_clk_f_d <= kb_clk_f;
      if (kb_clk_s2 != kb_clk_f) begin
        if (filt_cnt == FILT_LAST) begin
          kb_clk_f <= kb_clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall_stb = kb_clk_f_d && !kb_clk_f;
  assign timeout  = (state != ST_IDLE) && !fall_stb && (to_cnt == TO_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n   = state;
    bit_idx_n = bit_idx;
    shift_n   = shift_q;
    parity_n  = parity_q;
    push      = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    if (timeout) begin
      state_n = ST_IDLE;
      ferr_n  = 1'b1;
    end else if (fall_stb) begin
      case (state)
        ST_IDLE: begin
          if (!kb_data_s2) begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
            shift_n   = '0;
          end
        end
        ST_DATA: begin
          shift_n   = {kb_data_s2, shift_q[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          parity_n = kb_data_s2;
          state_n  = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (!kb_data_s2)                            ferr_n = 1'b1;
          else if (!odd_parity_ok(shift_q, parity_q)) perr_n = 1'b1;
          else                                        push   = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      shift_q    <= shift_n;
      parity_q   <= parity_n;
      to_cnt     <= (state == ST_IDLE || fall_stb) ? '0 : to_cnt + 1'b1;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      overflow   <= push && fifo_full && !(rd_en && !empty);
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (fifo_full),
    .count   (count)
  );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a PS/2 device model (time-scaled) drives
// frames, and hand-computed bytes, counts and pulses are compared.
module tb_ps2_keyboard_rx;
  import ps2_keyboard_rx_pkg::*;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 300;
  localparam int DEPTH      = 8;
  localparam int HALF       = 20;  // PS/2 half-period in clk cycles

  logic       clk;
  logic       reset_n;
  logic       kb_clk;
  logic       kb_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic [3:0] count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_perr   = 0;
  int n_ferr   = 0;
  int n_ovf    = 0;
  int last_ferr_cyc = 0;
  int last_fall_cyc = 0;
  int p0, f0, o0;

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .kb_clk     (kb_clk),
    .kb_data    (kb_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (overflow) n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drives one frame; nfalls truncates it, glitch adds short low pulses in each
  // high phase, pop_at_push raises rd_en for the cycle the stop bit is pushed.
  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic stop,
                            input int nfalls, input logic glitch, input logic pop_at_push);
    logic [10:0] bits;
    bits = {stop, ~(^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      kb_data = bits[i];
      if (glitch) begin
        repeat (3) @(negedge clk);
        kb_clk = 1'b0;
        repeat (2) @(negedge clk);
        kb_clk = 1'b1;
        repeat (HALF/2 - 5) @(negedge clk);
      end else begin
        repeat (HALF/2) @(negedge clk);
      end
      kb_clk = 1'b0;
      last_fall_cyc = cyc;
      if (pop_at_push && i == PS2_FRAME_BITS - 1) begin
        // Pad fall to push edge is 2 sync + FILTER_LEN filter + 1 strobe = 7 edges.
        repeat (6) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (HALF - 7) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      kb_clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
    end
    kb_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic good_frame(input logic [7:0] data);
    send_frame(data, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0, 1'b0);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic snap();
    p0 = n_perr;
    f0 = n_ferr;
    o0 = n_ovf;
  endtask

  initial begin
    reset_n = 1'b0;
    kb_clk  = 1'b1;
    kb_data = 1'b1;
    rd_en   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_errs", {parity_err, frame_err, overflow}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single frame 0x1C, then read it out
    snap();
    good_frame(8'h1C);
    check("t1_empty", empty, 0);
    check("t1_data", rd_data, 8'h1C);
    check("t1_count", count, 1);
    check("t1_no_errs", (n_perr - p0) + (n_ferr - f0) + (n_ovf - o0), 0);
    pop();
    check("t1_pop_empty", empty, 1);
    check("t1_pop_count", count, 0);

    // 2: F0 then 1C back-to-back keep order; F0 with bad parity dropped
    good_frame(PS2_BREAK_PREFIX);
    good_frame(8'h1C);
    check("t2_count", count, 2);
    check("t2_head0", rd_data, 8'hF0);
    pop();
    check("t2_head1", rd_data, 8'h1C);
    pop();
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0, 1'b0);
    check("t2_perr", n_perr - p0, 1);
    check("t2_perr_count", count, 0);
    check("t2_perr_noferr", n_ferr - f0, 0);

    // 3: bad stop bit, then clean 0x32
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, PS2_FRAME_BITS, 1'b0, 1'b0);
    check("t3_ferr", n_ferr - f0, 1);
    check("t3_no_push", empty, 1);
    good_frame(8'h32);
    check("t3_data", rd_data, 8'h32);
    check("t3_count", count, 1);
    pop();

    // 4: clock stops after 4 data bits -> timeout frame_err
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT + 50 && n_ferr == f0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("t4_timeout_pulse", n_ferr - f0, 1);
    check("t4_timeout_latency", last_ferr_cyc - last_fall_cyc, TIMEOUT + FILTER_LEN + 3);
    check("t4_no_push", empty, 1);
    good_frame(8'h1C);
    check("t4_after_data", rd_data, 8'h1C);
    pop();
    good_frame(PS2_EXT_PREFIX);
    check("t4_ext_data", rd_data, 8'hE0);
    pop();

    // 5: overflow on the 9th byte; simultaneous pop+push while full
    snap();
    for (int i = 1; i <= 9; i++) begin
      good_frame(8'(i));
      if (i == 8) begin
        check("t5_full_count", count, 8);
        check("t5_no_ovf_yet", n_ovf - o0, 0);
      end
    end
    check("t5_ovf", n_ovf - o0, 1);
    check("t5_count", count, 8);
    check("t5_head", rd_data, 8'h01);
    send_frame(8'h0A, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0, 1'b1);
    check("t5_pushpop_count", count, 8);
    check("t5_pushpop_no_ovf", n_ovf - o0, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_drain%0d", i), rd_data, (i < 7) ? 8'(i + 2) : 8'h0A);
      pop();
    end
    check("t5_drained", empty, 1);

    // 6: glitches ignored; reset mid-frame; post-reset frame
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b1, 1'b0);
    check("t6_glitch_data", rd_data, 8'h1C);
    check("t6_glitch_count", count, 1);
    check("t6_glitch_errs", (n_perr - p0) + (n_ferr - f0), 0);
    send_frame(8'h55, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_empty", empty, 1);
    check("t6_rst_count", count, 0);
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_errs", {parity_err, frame_err, overflow}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    good_frame(8'h1C);
    check("t6_post_data", rd_data, 8'h1C);
    check("t6_post_count", count, 1);
    check("t6_post_errs", (n_perr - p0) + (n_ferr - f0) + (n_ovf - o0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
